ahblite_busmatrix_arbiter_rr: RTL and testbench



---
 rtl/ahblite_busmatrix_arbiter_rr_if.sv | 33 +++
 rtl/ahblite_busmatrix_arbiter_rr.sv | 134 +++++++++++++
 tb/tb_ahblite_busmatrix_arbiter_rr.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ahblite_busmatrix_arbiter_rr_if.sv
// rtl/ahblite_busmatrix_arbiter_rr_if.sv - request/observe/grant bundle between output stage and its arbiter
// Ports (signals):
//   REQ_DMA/REQ_ICODE/REQ_DCODE/REQ_SYS  requester wants the slave port
//   HREADY_Outputstage, HSEL_Outputstage, HTRANS_Outputstage, HBURST_Outputstage
//                                         transfer currently driven to the slave
//   PORT_SEL, PORT_NOSEL, BURST_LOCK      grant back to the output stage
// Modports: slave = arbiter side, master = output-stage side.

interface ahblite_busmatrix_arbiter_rr_if;
    logic       REQ_DMA;
    logic       REQ_ICODE;
    logic       REQ_DCODE;
    logic       REQ_SYS;
    logic       HREADY_Outputstage;
    logic       HSEL_Outputstage;
    logic [1:0] HTRANS_Outputstage;
    logic [2:0] HBURST_Outputstage;
    logic [1:0] PORT_SEL;
    logic       PORT_NOSEL;
    logic       BURST_LOCK;

    modport slave (
        input  REQ_DMA, REQ_ICODE, REQ_DCODE, REQ_SYS,
        input  HREADY_Outputstage, HSEL_Outputstage, HTRANS_Outputstage, HBURST_Outputstage,
        output PORT_SEL, PORT_NOSEL, BURST_LOCK
    );

    modport master (
        output REQ_DMA, REQ_ICODE, REQ_DCODE, REQ_SYS,
        output HREADY_Outputstage, HSEL_Outputstage, HTRANS_Outputstage, HBURST_Outputstage,
        input  PORT_SEL, PORT_NOSEL, BURST_LOCK
    );
endinterface

// File: rtl/ahblite_busmatrix_arbiter_rr.sv
// rtl/ahblite_busmatrix_arbiter_rr.sv - four-requester burst-aware arbiter for one bus-matrix output stage
// Ports:
//   HCLK     clock
//   HRESETn  asynchronous active-low reset
//   bus      ahblite_busmatrix_arbiter_rr_if.slave (requests, observed transfer, grant outputs)
// Parameter PRIORITY_MODE: 0 = round-robin, 1 = fixed DCODE > ICODE > SYS > DMA.

module ahblite_busmatrix_arbiter_rr #(
    parameter bit PRIORITY_MODE = 1'b0
) (
    input  logic                            HCLK,
    input  logic                            HRESETn,
    ahblite_busmatrix_arbiter_rr_if.slave   bus
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic [2:0] HBURST_INCR   = 3'b001;

    logic [1:0] sel_q,   sel_d;
    logic       nosel_q, nosel_d;
    logic [3:0] cnt_q,   cnt_d;
    logic       lock_q,  lock_d;
    logic [1:0] ptr_q,   ptr_d;

    // Bit index equals the PORT_SEL encoding of each requester.
    logic [3:0] req;
    logic [3:0] burst_len_m1;
    logic       hold;
    logic [3:0] cnt_next;
    logic       any_req;
    logic [1:0] winner;
    logic [1:0] idx;

    always_comb begin
        req = {bus.REQ_SYS, bus.REQ_DCODE, bus.REQ_ICODE, bus.REQ_DMA};

        case (bus.HBURST_Outputstage)
            3'b010, 3'b011: burst_len_m1 = 4'd3;
            3'b100, 3'b101: burst_len_m1 = 4'd7;
            3'b110, 3'b111: burst_len_m1 = 4'd15;
            default:        burst_len_m1 = 4'd0;
        endcase

        // Burst tracking: decides whether the current owner keeps the port.
        hold     = 1'b0;
        cnt_next = 4'd0;
        if (bus.HSEL_Outputstage) begin
            if (bus.HTRANS_Outputstage == HTRANS_NONSEQ && cnt_q != 4'd0) begin
                // Early termination of a fixed-length burst: release.
                hold     = 1'b0;
                cnt_next = 4'd0;
            end else if (bus.HTRANS_Outputstage == HTRANS_NONSEQ && burst_len_m1 != 4'd0) begin
                hold     = 1'b1;
                cnt_next = burst_len_m1;
            end else if (bus.HTRANS_Outputstage == HTRANS_SEQ && cnt_q > 4'd1) begin
                hold     = 1'b1;
                cnt_next = cnt_q - 4'd1;
            end else if (bus.HTRANS_Outputstage == HTRANS_SEQ && cnt_q == 4'd1) begin
                // Final beat accepted: hand over on this same edge.
                hold     = 1'b0;
                cnt_next = 4'd0;
            end else if (bus.HTRANS_Outputstage == HTRANS_BUSY && cnt_q != 4'd0) begin
                hold     = 1'b1;
                cnt_next = cnt_q;
            end else if (bus.HBURST_Outputstage == HBURST_INCR &&
                         bus.HTRANS_Outputstage != HTRANS_IDLE) begin
                // Undefined length: held until IDLE or deselect.
                hold     = 1'b1;
                cnt_next = 4'd0;
            end
        end

        any_req = |req;
        winner  = sel_q;
        idx     = 2'd0;
        if (PRIORITY_MODE) begin
            if (req[2])      winner = 2'd2;
            else if (req[1]) winner = 2'd1;
            else if (req[3]) winner = 2'd3;
            else if (req[0]) winner = 2'd0;
        end else begin
            // Scan ptr+1 .. ptr+4; the last owner is considered last.
            for (int i = 4; i >= 1; i--) begin
                idx = ptr_q + 2'(i);
                if (req[idx]) winner = idx;
            end
        end

        sel_d   = sel_q;
        nosel_d = nosel_q;
        cnt_d   = cnt_q;
        lock_d  = lock_q;
        ptr_d   = ptr_q;
        if (bus.HREADY_Outputstage) begin
            cnt_d = cnt_next;
            if (hold) begin
                lock_d = 1'b1;
            end else begin
                lock_d = 1'b0;
                if (any_req) begin
                    sel_d   = winner;
                    nosel_d = 1'b0;
                    if (!PRIORITY_MODE) ptr_d = winner;
                end else begin
                    nosel_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sel_q   <= 2'b00;
            nosel_q <= 1'b1;
            cnt_q   <= 4'd0;
            lock_q  <= 1'b0;
            ptr_q   <= 2'b11;
        end else begin
            sel_q   <= sel_d;
            nosel_q <= nosel_d;
            cnt_q   <= cnt_d;
            lock_q  <= lock_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.PORT_SEL   = sel_q;
    assign bus.PORT_NOSEL = nosel_q;
    assign bus.BURST_LOCK = lock_q;

endmodule

// File: tb/tb_ahblite_busmatrix_arbiter_rr.sv
// tb/tb_ahblite_busmatrix_arbiter_rr.sv - self-checking bench for round-robin and fixed-priority arbiters

module tb_ahblite_busmatrix_arbiter_rr;

    logic HCLK;
    logic HRESETn;

    ahblite_busmatrix_arbiter_rr_if bus_rr ();
    ahblite_busmatrix_arbiter_rr_if bus_fx ();

    ahblite_busmatrix_arbiter_rr #(.PRIORITY_MODE(1'b0)) u_rr (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus_rr)
    );

    ahblite_busmatrix_arbiter_rr #(.PRIORITY_MODE(1'b1)) u_fx (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus_fx)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int total = 0;
    int bad   = 0;

    // Current stimulus, shared by both arbiters.
    logic       c_hready;
    logic       c_hsel;
    logic [1:0] c_htrans;
    logic [2:0] c_hburst;
    logic [3:0] c_req;       // bit0 DMA, bit1 ICODE, bit2 DCODE, bit3 SYS

    // Reference model, index 0 = round-robin, 1 = fixed priority.
    int m_sel[2];
    int m_nosel[2];
    int m_lock[2];
    int m_remain[2];         // beats still to be accepted after the current one
    int m_last[2];
    int fixed_order[4] = '{2, 1, 3, 0};
    int burst_beats[8] = '{1, 0, 4, 4, 8, 8, 16, 16};

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_sel[m] = 0; m_nosel[m] = 1; m_lock[m] = 0; m_remain[m] = 0; m_last[m] = 3;
        end
    endtask

    task automatic model_edge();
        int  beats;
        bit  keep;
        int  nrem;
        int  w;
        if (!c_hready) return;
        beats = burst_beats[c_hburst];
        for (int m = 0; m < 2; m++) begin
            keep = 0;
            nrem = 0;
            if (c_hsel) begin
                case (c_htrans)
                    2'b10: begin
                        if (m_remain[m] == 0 && beats > 1) begin keep = 1; nrem = beats - 1; end
                        else if (m_remain[m] == 0 && c_hburst == 3'b001) keep = 1;
                    end
                    2'b11: begin
                        if (m_remain[m] > 1) begin keep = 1; nrem = m_remain[m] - 1; end
                        else if (m_remain[m] == 0 && c_hburst == 3'b001) keep = 1;
                    end
                    2'b01: begin
                        if (m_remain[m] >= 1) begin keep = 1; nrem = m_remain[m]; end
                        else if (c_hburst == 3'b001) keep = 1;
                    end
                    default: ;
                endcase
            end
            m_remain[m] = nrem;
            if (keep) begin
                m_lock[m] = 1;
            end else begin
                m_lock[m] = 0;
                w = -1;
                for (int k = 0; k < 4; k++) begin
                    int p;
                    p = (m == 0) ? (m_last[m] + 1 + k) % 4 : fixed_order[k];
                    if (w < 0 && c_req[p]) w = p;
                end
                if (w >= 0) begin
                    m_sel[m] = w;
                    m_nosel[m] = 0;
                    if (m == 0) m_last[m] = w;
                end else begin
                    m_nosel[m] = 1;
                end
            end
        end
    endtask

    task automatic drive(input logic hr, input logic hs, input logic [1:0] ht,
                         input logic [2:0] hb, input logic [3:0] rq);
        c_hready = hr; c_hsel = hs; c_htrans = ht; c_hburst = hb; c_req = rq;
        bus_rr.HREADY_Outputstage = hr; bus_fx.HREADY_Outputstage = hr;
        bus_rr.HSEL_Outputstage   = hs; bus_fx.HSEL_Outputstage   = hs;
        bus_rr.HTRANS_Outputstage = ht; bus_fx.HTRANS_Outputstage = ht;
        bus_rr.HBURST_Outputstage = hb; bus_fx.HBURST_Outputstage = hb;
        bus_rr.REQ_DMA   = rq[0]; bus_fx.REQ_DMA   = rq[0];
        bus_rr.REQ_ICODE = rq[1]; bus_fx.REQ_ICODE = rq[1];
        bus_rr.REQ_DCODE = rq[2]; bus_fx.REQ_DCODE = rq[2];
        bus_rr.REQ_SYS   = rq[3]; bus_fx.REQ_SYS   = rq[3];
    endtask

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "/rr_sel"},   {2'b00, bus_rr.PORT_SEL},   4'(m_sel[0]));
        check({tag, "/rr_nosel"}, {3'b000, bus_rr.PORT_NOSEL}, 4'(m_nosel[0]));
        check({tag, "/rr_lock"},  {3'b000, bus_rr.BURST_LOCK}, 4'(m_lock[0]));
        check({tag, "/fx_sel"},   {2'b00, bus_fx.PORT_SEL},   4'(m_sel[1]));
        check({tag, "/fx_nosel"}, {3'b000, bus_fx.PORT_NOSEL}, 4'(m_nosel[1]));
        check({tag, "/fx_lock"},  {3'b000, bus_fx.BURST_LOCK}, 4'(m_lock[1]));
    endtask

    task automatic cycle(input string tag, input logic hr, input logic hs, input logic [1:0] ht,
                         input logic [2:0] hb, input logic [3:0] rq);
        drive(hr, hs, ht, hb, rq);
        @(posedge HCLK);
        model_edge();
        #1;
        check_model(tag);
    endtask

    task automatic pulse_reset();
        HRESETn = 1'b0;
        #1;
        model_reset();
        check_model("reset");
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
    endtask

    int exp_seq[5] = '{0, 1, 2, 3, 0};

    initial begin
        drive(1'b0, 1'b0, 2'b00, 3'b000, 4'b0000);
        HRESETn = 1'b0;
        model_reset();
        #12;
        check_model("por");
        check("por_rr_nosel", {3'b000, bus_rr.PORT_NOSEL}, 4'd1);
        HRESETn = 1'b1;
        #4;

        // ICODE alone: nothing happens while HREADY is low, then granted.
        cycle("icode_wait", 1'b0, 1'b0, 2'b00, 3'b000, 4'b0010);
        check("icode_wait_nosel", {3'b000, bus_rr.PORT_NOSEL}, 4'd1);
        cycle("icode_grant", 1'b1, 1'b0, 2'b00, 3'b000, 4'b0010);
        check("icode_rr_sel", {2'b00, bus_rr.PORT_SEL}, 4'd1);
        check("icode_fx_sel", {2'b00, bus_fx.PORT_SEL}, 4'd1);

        // Round-robin rotation with single transfers.
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            cycle("rr_rotate", 1'b1, 1'b1, 2'b10, 3'b000, 4'b1111);
            check("rr_rotate_sel", {2'b00, bus_rr.PORT_SEL}, 4'(exp_seq[i]));
            check("fx_all_dcode", {2'b00, bus_fx.PORT_SEL}, 4'd2);
        end

        // INCR4 with one BUSY: owner 00 kept for the burst, ICODE next.
        cycle("incr4_ns",   1'b1, 1'b1, 2'b10, 3'b011, 4'b1111);
        cycle("incr4_s1",   1'b1, 1'b1, 2'b11, 3'b011, 4'b1111);
        cycle("incr4_busy", 1'b1, 1'b1, 2'b01, 3'b011, 4'b1111);
        cycle("incr4_s2",   1'b1, 1'b1, 2'b11, 3'b011, 4'b1111);
        check("incr4_locked", {1'b0, bus_rr.BURST_LOCK, bus_rr.PORT_SEL}, 4'b0100);
        cycle("incr4_s3",   1'b1, 1'b1, 2'b11, 3'b011, 4'b1111);
        check("incr4_handover", {1'b0, bus_rr.BURST_LOCK, bus_rr.PORT_SEL}, 4'b0001);

        // INCR undefined length with an HREADY-low stall, ended by IDLE.
        cycle("incr_ns", 1'b1, 1'b1, 2'b10, 3'b001, 4'b1111);
        for (int i = 0; i < 6; i++) begin
            if (i == 3) begin
                for (int j = 0; j < 3; j++) cycle("incr_stall", 1'b0, 1'b1, 2'b11, 3'b001, 4'b1111);
            end
            cycle("incr_seq", 1'b1, 1'b1, 2'b11, 3'b001, 4'b1111);
            check("incr_held", {1'b0, bus_rr.BURST_LOCK, bus_rr.PORT_SEL}, 4'b0101);
        end
        cycle("incr_idle", 1'b1, 1'b1, 2'b00, 3'b001, 4'b1111);
        check("incr_release", {1'b0, bus_rr.BURST_LOCK, bus_rr.PORT_SEL}, 4'b0010);

        // Fixed priority: SYS over DMA, then DCODE once it asks.
        pulse_reset();
        for (int i = 0; i < 3; i++) begin
            cycle("fx_sys", 1'b1, 1'b0, 2'b00, 3'b000, 4'b1001);
            check("fx_sys_sel", {2'b00, bus_fx.PORT_SEL}, 4'd3);
        end
        for (int i = 0; i < 3; i++) begin
            cycle("fx_dcode", 1'b1, 1'b0, 2'b00, 3'b000, 4'b1101);
            check("fx_dcode_sel", {2'b00, bus_fx.PORT_SEL}, 4'd2);
        end

        // Async reset in the middle of a WRAP8 burst.
        pulse_reset();
        cycle("wrap8_ns", 1'b1, 1'b1, 2'b10, 3'b100, 4'b1111);
        cycle("wrap8_s1", 1'b1, 1'b1, 2'b11, 3'b100, 4'b1111);
        cycle("wrap8_s2", 1'b1, 1'b1, 2'b11, 3'b100, 4'b1111);
        check("wrap8_locked", {3'b000, bus_rr.BURST_LOCK}, 4'd1);
        #2;
        HRESETn = 1'b0;
        #1;
        model_reset();
        check("async_rr", {bus_rr.PORT_NOSEL, bus_rr.BURST_LOCK, bus_rr.PORT_SEL}, 4'b1000);
        check("async_fx", {bus_fx.PORT_NOSEL, bus_fx.BURST_LOCK, bus_fx.PORT_SEL}, 4'b1000);
        #2;
        HRESETn = 1'b1;
        cycle("post_reset_sys", 1'b1, 1'b0, 2'b00, 3'b000, 4'b1000);
        check("post_reset_rr", {bus_rr.PORT_NOSEL, bus_rr.BURST_LOCK, bus_rr.PORT_SEL}, 4'b0011);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic       hr;
            logic       hs;
            logic [1:0] ht;
            logic [2:0] hb;
            logic [3:0] rq;
            hr = ($urandom_range(3) != 0);
            hs = ($urandom_range(7) != 0);
            ht = 2'($urandom);
            hb = 3'($urandom);
            rq = 4'($urandom);
            cycle("random", hr, hs, ht, hb, rq);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
